// File: rtl/jump_target_unit.sv
// rtl/jump_target_unit.sv - registered next-PC stage for JAL/JALR/branches with a circular return-address stack
module jump_target_unit #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] cur_pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rd_idx,
    input  logic [19:0]     imm_j,
    input  logic [11:0]     imm_i,
    input  logic [11:0]     imm_b,
    input  logic            br_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] link_addr,
    output logic            misalign,
    output logic            ras_pop,
    output logic            ras_hit,
    output logic [XLEN-1:0] ras_pred
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_JAL    = 2'b01;
    localparam logic [1:0] OP_JALR   = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic [XLEN-1:0] link_addr_q, link_addr_d;
    logic            misalign_q, misalign_d;
    logic            ras_pop_q, ras_pop_d;
    logic            ras_hit_q, ras_hit_d;
    logic [XLEN-1:0] ras_pred_q, ras_pred_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            do_push;
    logic            do_pop;
    logic            rd_link;
    logic            rs1_link;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] top_entry;
    logic [PW-1:0]   top_idx;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign next_pc   = next_pc_q;
    assign link_addr = link_addr_q;
    assign misalign  = misalign_q;
    assign ras_pop   = ras_pop_q;
    assign ras_hit   = ras_hit_q;
    assign ras_pred  = ras_pred_q;

    always_comb begin
        accept    = in_valid && in_ready && !flush;
        rd_link   = (rd_idx == 5'd1) || (rd_idx == 5'd5);
        rs1_link  = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);
        link      = cur_pc + XLEN'(4);
        target    = link;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        case (op)
            OP_JAL: begin
                target  = cur_pc + XLEN'($signed({imm_j, 1'b0}));
                do_push = rd_link;
            end
            OP_JALR: begin
                target    = rs1_val + XLEN'($signed(imm_i));
                target[0] = 1'b0;
                do_pop    = rs1_link && !(rd_link && rd_idx == rs1_idx);
                do_push   = rd_link;
            end
            OP_BRANCH: begin
                if (br_taken) begin
                    target = cur_pc + XLEN'($signed({imm_b, 1'b0}));
                end
            end
            default: target = link;
        endcase

        top_idx   = ptr_q - 1'b1;
        top_entry = (cnt_q != '0) ? ras_q[top_idx] : '0;

        out_valid_d = out_valid_q;
        next_pc_d   = next_pc_q;
        link_addr_d = link_addr_q;
        misalign_d  = misalign_q;
        ras_pop_d   = ras_pop_q;
        ras_hit_d   = ras_hit_q;
        ras_pred_d  = ras_pred_q;
        ras_d       = ras_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            next_pc_d   = target;
            link_addr_d = link;
            misalign_d  = target[1];
            ras_pop_d   = do_pop;
            ras_pred_d  = do_pop ? top_entry : '0;
            ras_hit_d   = do_pop && (cnt_q != '0) && (top_entry == target);
            // Pop is applied first so a pop+push lands in the slot just vacated.
            if (do_pop && cnt_q != '0) begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
            if (do_push) begin
                ras_d[ptr_d] = link;
                ptr_d        = ptr_d + 1'b1;
                if (cnt_d != CW'(RAS_DEPTH)) begin
                    cnt_d = cnt_d + 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            out_valid_d = 1'b0;
            next_pc_d   = '0;
            link_addr_d = '0;
            misalign_d  = 1'b0;
            ras_pop_d   = 1'b0;
            ras_hit_d   = 1'b0;
            ras_pred_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            next_pc_q   <= '0;
            link_addr_q <= '0;
            misalign_q  <= 1'b0;
            ras_pop_q   <= 1'b0;
            ras_hit_q   <= 1'b0;
            ras_pred_q  <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            next_pc_q   <= next_pc_d;
            link_addr_q <= link_addr_d;
            misalign_q  <= misalign_d;
            ras_pop_q   <= ras_pop_d;
            ras_hit_q   <= ras_hit_d;
            ras_pred_q  <= ras_pred_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ras_q       <= ras_d;
        end
    end
endmodule

// File: tb/tb_jump_target_unit.sv
// tb/tb_jump_target_unit.sv - scoreboard bench for jump_target_unit with directed vectors
module tb_jump_target_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] cur_pc = '0;
    logic [31:0] rs1_val = '0;
    logic [4:0]  rs1_idx = '0;
    logic [4:0]  rd_idx = '0;
    logic [19:0] imm_j = '0;
    logic [11:0] imm_i = '0;
    logic [11:0] imm_b = '0;
    logic        br_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] next_pc;
    logic [31:0] link_addr;
    logic        misalign;
    logic        ras_pop;
    logic        ras_hit;
    logic [31:0] ras_pred;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] link;
        logic        mis;
        logic        pop;
        logic        hit;
        logic [31:0] pred;
    } exp_t;

    exp_t sb[$];

    jump_target_unit #(.XLEN(32), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .cur_pc(cur_pc), .rs1_val(rs1_val),
        .rs1_idx(rs1_idx), .rd_idx(rd_idx),
        .imm_j(imm_j), .imm_i(imm_i), .imm_b(imm_b), .br_taken(br_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .next_pc(next_pc), .link_addr(link_addr), .misalign(misalign),
        .ras_pop(ras_pop), .ras_hit(ras_hit), .ras_pred(ras_pred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got output next_pc %h expected none", next_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("next_pc", next_pc, e.npc);
                chk("link_addr", link_addr, e.link);
                chk("misalign", 32'(misalign), 32'(e.mis));
                chk("ras_pop", 32'(ras_pop), 32'(e.pop));
                chk("ras_hit", 32'(ras_hit), 32'(e.hit));
                chk("ras_pred", ras_pred, e.pred);
            end
        end
    end

    task automatic set_in(input logic [1:0] o, input logic [31:0] pc, input logic [31:0] rv,
                          input logic [4:0] rs1, input logic [4:0] rd, input logic [19:0] ij,
                          input logic [11:0] ii, input logic [11:0] ib, input logic tk);
        op = o; cur_pc = pc; rs1_val = rv; rs1_idx = rs1; rd_idx = rd;
        imm_j = ij; imm_i = ii; imm_b = ib; br_taken = tk;
    endtask

    // Inputs are applied just after a rising edge; waits for in_ready and records the expectation.
    task automatic issue(input logic [1:0] o, input logic [31:0] pc, input logic [31:0] rv,
                         input logic [4:0] rs1, input logic [4:0] rd, input logic [19:0] ij,
                         input logic [11:0] ii, input logic [11:0] ib, input logic tk,
                         input logic [31:0] enpc, input logic emis, input logic epop,
                         input logic ehit, input logic [31:0] epred);
        exp_t e;
        bit done = 0;
        set_in(o, pc, rv, rs1, rd, ij, ii, ib, tk);
        in_valid = 1'b1;
        e.npc = enpc; e.link = pc + 32'd4; e.mis = emis;
        e.pop = epop; e.hit = ehit; e.pred = epred;
        for (int g = 0; g < 50 && !done; g++) begin
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_link", link_addr, 32'd0);
        chk("rst_ras_pred", ras_pred, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // JAL push then matching return
        issue(2'b01, 32'h1000, 0, 0, 1, 20'h00010, 0, 0, 0, 32'h1020, 0, 0, 0, 0);
        issue(2'b10, 32'h1020, 32'h1004, 1, 0, 0, 12'h000, 0, 0, 32'h1004, 0, 1, 1, 32'h1004);
        // branches and wrap
        issue(2'b11, 32'h2000, 0, 0, 0, 0, 0, 12'hFFE, 1, 32'h1FFC, 0, 0, 0, 0);
        issue(2'b11, 32'h2000, 0, 0, 0, 0, 0, 12'hFFE, 0, 32'h2004, 0, 0, 0, 0);
        issue(2'b00, 32'h2100, 0, 0, 0, 0, 0, 0, 0, 32'h2104, 0, 0, 0, 0);
        issue(2'b01, 32'hFFFFFFFC, 0, 0, 0, 20'h00002, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        // JALR misalignment, negative imm, pop on empty
        issue(2'b10, 32'h3100, 32'h3003, 2, 0, 0, 12'h000, 0, 0, 32'h3002, 1, 0, 0, 0);
        issue(2'b10, 32'h3100, 32'h3000, 2, 0, 0, 12'hFFF, 0, 0, 32'h2FFE, 1, 0, 0, 0);
        issue(2'b10, 32'h3200, 32'h0100, 5, 0, 0, 12'h000, 0, 0, 32'h0100, 0, 1, 0, 0);
        // five pushes into a 4-deep stack, then five returns
        for (int k = 1; k <= 5; k++)
            issue(2'b01, 32'(k * 256), 0, 0, 1, 20'h00008, 0, 0, 0, 32'(k * 256 + 16), 0, 0, 0, 0);
        for (int k = 5; k >= 2; k--)
            issue(2'b10, 32'h9000, 32'(k * 256 + 4), 1, 0, 0, 0, 0, 0,
                  32'(k * 256 + 4), 0, 1, 1, 32'(k * 256 + 4));
        issue(2'b10, 32'h9000, 32'h104, 1, 0, 0, 0, 0, 0, 32'h104, 0, 1, 0, 0);
        // prediction miss
        issue(2'b01, 32'h600, 0, 0, 5, 20'h00008, 0, 0, 0, 32'h610, 0, 0, 0, 0);
        issue(2'b10, 32'h610, 32'h700, 5, 0, 0, 0, 0, 0, 32'h700, 0, 1, 0, 32'h604);
        // pop-then-push replaces top
        issue(2'b01, 32'h800, 0, 0, 1, 20'h00008, 0, 0, 0, 32'h810, 0, 0, 0, 0);
        issue(2'b10, 32'h880, 32'h900, 1, 5, 0, 0, 0, 0, 32'h900, 0, 1, 0, 32'h804);
        issue(2'b10, 32'h900, 32'h884, 5, 0, 0, 0, 0, 0, 32'h884, 0, 1, 1, 32'h884);
        issue(2'b10, 32'h900, 32'h884, 5, 0, 0, 0, 0, 0, 32'h884, 0, 1, 0, 0);
        // rd==rs1 link: push only
        issue(2'b10, 32'hA00, 32'hB00, 1, 1, 0, 0, 0, 0, 32'hB00, 0, 0, 0, 0);
        issue(2'b10, 32'hB00, 32'hA04, 1, 0, 0, 0, 0, 0, 32'hA04, 0, 1, 1, 32'hA04);

        // backpressure: result held, pending JAL not accepted
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(2'b00, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 32'h4004, 0, 0, 0, 0);
        set_in(2'b01, 32'h5000, 0, 0, 1, 20'h00008, 0, 0, 0);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_next_pc", next_pc, 32'h4004);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        issue(2'b10, 32'hC00, 32'h0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0);

        // flush drops a held result
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(2'b00, 32'h4100, 0, 0, 0, 0, 0, 0, 0, 32'h4104, 0, 0, 0, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb.pop_back());
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_held_valid", 32'(out_valid), 32'd0);
        // flush discards a same-cycle accept, including its push
        @(posedge clk); #1;
        set_in(2'b01, 32'h6000, 0, 0, 1, 20'h00008, 0, 0, 0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_acc_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        issue(2'b10, 32'hD00, 32'h10, 1, 0, 0, 0, 0, 0, 32'h10, 0, 1, 0, 0);

        // reset mid-stream clears outputs and the stack
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(2'b01, 32'h7000, 0, 0, 1, 20'h00008, 0, 0, 0, 32'h7010, 0, 0, 0, 0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_next_pc", next_pc, 32'd0);
        chk("mid_rst_link", link_addr, 32'd0);
        chk("mid_rst_pop", 32'(ras_pop), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        issue(2'b10, 32'hE00, 32'h20, 1, 0, 0, 0, 0, 0, 32'h20, 0, 1, 0, 0);

        for (int g = 0; g < 20 && sb.size() != 0; g++) @(posedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jump_target_unit.md
Name: jump_target_unit

Overview:
Parametrised successor to the single-purpose JAL destination adder: one registered stage computing the next PC for JAL, JALR and conditional branches, plus a small circular return-address stack (RAS) that predicts and checks JALR returns. Sits between decode and the PC register; a valid/ready handshake lets the fetch stage stall it.

Parameters:
XLEN, 32, datapath width for PC, rs1 value and computed addresses
RAS_DEPTH, 4, number of RAS entries, power of two, at least 2

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  drop the output register contents; RAS unaffected
in_valid  in  1  request valid
in_ready  out  1  request accepted this cycle when high with in_valid
op  in  2  00 NOP (pc+4), 01 JAL, 10 JALR, 11 BRANCH
cur_pc  in  XLEN  PC of the instruction
rs1_val  in  XLEN  rs1 operand, JALR only
rs1_idx  in  5  rs1 register index
rd_idx  in  5  rd register index
imm_j  in  20  raw J immediate, bits [20:1]
imm_i  in  12  raw I immediate
imm_b  in  12  raw B immediate, bits [12:1]
br_taken  in  1  branch condition result, BRANCH only
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
next_pc  out  XLEN  computed next PC
link_addr  out  XLEN  cur_pc+4
misalign  out  1  next_pc[1] set
ras_pop  out  1  this result consumed a RAS entry
ras_hit  out  1  popped entry equals next_pc (0 if RAS was empty)
ras_pred  out  XLEN  popped entry, 0 if empty or no pop

Behaviour:
- Reset: all outputs 0, out_valid=0, RAS count=0, top pointer=0, entries cleared to 0.
- in_ready = !out_valid || out_ready; combinational, no dependency on in_valid. Accept = in_valid && in_ready.
- Latency 1: on accept, results are registered and out_valid=1 next cycle. Result held stable while out_valid && !out_ready. out_valid clears on out_ready without a new accept.
- flush: out_valid cleared next cycle; accept in the same cycle is discarded (no RAS update, no output). flush has priority over accept. rst has priority over everything.
- Arithmetic, all modulo 2^XLEN (carry dropped, wrap allowed):
  NOP: cur_pc+4. JAL: cur_pc + (sext(imm_j)<<1). JALR: (rs1_val + sext(imm_i)) with bit0 forced to 0. BRANCH: br_taken ? cur_pc + (sext(imm_b)<<1) : cur_pc+4.
- misalign = next_pc[1]; reported only, no behavioural change.
- Link register test L(x) = (x==1 || x==5).
- RAS actions on accept only (not on flush):
  JAL with L(rd): push link_addr.
  JALR: !L(rd)&&L(rs1): pop. L(rd)&&!L(rs1): push. L(rd)&&L(rs1)&&rd!=rs1: pop then push (replace top). L(rd)&&L(rs1)&&rd==rs1: push only.
  NOP, BRANCH: no action.
- Pop reads top before any push in the same accept; ras_pred/ras_hit/ras_pop registered with the result.
- Pop on empty: ras_pop=1, ras_hit=0, ras_pred=0, count stays 0.
- Push on full: overwrites oldest entry (circular), count saturates at RAS_DEPTH.
- Pop-then-push: count unchanged; top entry replaced by the new link.

Test Plan:
- Reset, then JAL pc=0x1000 imm_j=0x00010 rd=1 -> next cycle next_pc=0x1020, link_addr=0x1004, misalign=0, RAS count 1.
- Then JALR rs1=1 rd=0 rs1_val=0x1004 imm_i=0 -> next_pc=0x1004, ras_pop=1, ras_hit=1, ras_pred=0x1004, count 0.
- BRANCH pc=0x2000 imm_b=0xFFE (-2) taken -> 0x1FFC; not taken -> 0x2004. JAL pc=0xFFFFFFFC imm_j=2 -> 0x00000000 (wrap).
- JALR rs1_val=0x3003 imm_i=0 -> next_pc=0x3002, misalign=1. Pop on empty RAS -> ras_pop=1, ras_hit=0, ras_pred=0.
- Five JAL rd=1 pushes (links A..E) with RAS_DEPTH=4, then four return pops -> E,D,C,B, then a fifth pop gets ras_hit=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no RAS change. flush with in_valid -> out_valid=0 next cycle, RAS count unchanged. rst mid-stream -> all outputs 0 next cycle.
